// File: rtl/data_mem_resp_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package data_mem_resp_pkg;

  localparam int N_MEM_ADDR  = 32;
  localparam int N_MEM_DATA  = 32;
  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Expands a 4-bit byte-enable into a full-word bit mask.
  function automatic logic [N_MEM_DATA-1:0] sel_mask(input logic [3:0] sel);
    for (int k = 0; k < 4; k++) begin
      sel_mask[8*k +: 8] = {8{sel[k]}};
    end
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// MEM stage <-> data-memory responder bus; master is the MEM stage, slave the responder.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic                  i_ce;
  logic                  i_we;
  logic [N_MEM_ADDR-1:0] i_addr;
  logic [3:0]            i_sel;
  logic [N_MEM_DATA-1:0] i_wdata;
  logic [N_MEM_DATA-1:0] o_rdata;
  logic                  o_ready;
  logic                  o_stallreq;

  modport master (
    output i_ce, i_we, i_addr, i_sel, i_wdata,
    input  o_rdata, o_ready, o_stallreq
  );

  modport slave (
    input  i_ce, i_we, i_addr, i_sel, i_wdata,
    output o_rdata, o_ready, o_stallreq
  );

endinterface

// File: rtl/data_mem_resp_dmem_bank.sv
// Byte-enabled single-port synchronous RAM; read data is registered and held between loads.
module dmem_bank
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            sel,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [N_MEM_DATA-1:0] wdata,
  output logic [N_MEM_DATA-1:0] rdata
);

  logic [N_MEM_DATA-1:0] mem [2**ADDR_W];

  // NOTE: no reset on the array or read register -- contents must survive reset and a
  // reset port would stop this mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= (mem[addr] & ~sel_mask(sel)) | (wdata & sel_mask(sel));
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: latches a MEM-stage request, waits WAIT_CYCLES, then completes it
// against dmem_bank while holding the pipeline stalled.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  data_mem_resp_if.slave bus
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

  typedef struct packed {
    logic                  we;
    logic [3:0]            sel;
    logic [DEPTH_LOG2-1:0] widx;
    logic [N_MEM_DATA-1:0] wdata;
  } req_t;

  dmem_state_e           state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
  req_t                  req_q, cur_req;
  logic                  rdata_vld_q;
  logic                  enter_resp;
  logic [N_MEM_DATA-1:0] bank_rdata;
  logic                  unused_addr;

  assign unused_addr = ^{bus.i_addr[N_MEM_ADDR-1:DEPTH_LOG2+2], bus.i_addr[1:0]};

  // In IDLE the live inputs drive the bank so a zero-wait access completes on acceptance.
  assign cur_req = (state_q == IDLE)
                 ? '{we: bus.i_we, sel: bus.i_sel,
                     widx: bus.i_addr[DEPTH_LOG2+1:2], wdata: bus.i_wdata}
                 : req_q;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_ce) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!bus.i_ce) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.i_ce) begin
        req_q <= cur_req;
      end
      if (enter_resp && !cur_req.we) begin
        rdata_vld_q <= 1'b1;
      end
    end
  end

  dmem_bank #(.ADDR_W(DEPTH_LOG2)) u_bank (
    .clk   (i_clk),
    .en    (enter_resp),
    .we    (cur_req.we),
    .sel   (cur_req.sel),
    .addr  (cur_req.widx),
    .wdata (cur_req.wdata),
    .rdata (bank_rdata)
  );

  // The bank's read register is not reset; mask it until the first load after reset.
  assign bus.o_rdata    = rdata_vld_q ? bank_rdata : '0;
  assign bus.o_ready    = (state_q == RESP);
  assign bus.o_stallreq = bus.i_ce && (state_q != RESP);

endmodule
